// File: rtl/tqvp_bus_pkg.sv
// -----------------------------------------------------------------------------
// tqvp_bus_pkg
//
// Shared types and helpers for the TinyQV peripheral bus sequencer.
//   size_e      : access size code, doubles as the active-low strobe encoding
//   BUS_IDLE    : strobe value driven when no access is in progress
//   state_e     : sequencer FSM states
//   is_aligned  : natural-alignment check for a size / low address bits pair
//   mask_rdata  : zero-extends read data to the access size
// -----------------------------------------------------------------------------
package tqvp_bus_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } size_e;

    // Strobes are "size code when active, 11 when idle"; 11 is also the illegal size.
    localparam logic [1:0] BUS_IDLE = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } state_e;

    // Only the two low address bits matter for natural alignment.
    function automatic logic is_aligned(input size_e size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            BYTE:    ok = 1'b1;
            HALF:    ok = ~addr_lo[0];
            WORD:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] mask_rdata(input size_e size, input logic [31:0] data);
        logic [31:0] res;
        case (size)
            BYTE:    res = {24'h0, data[7:0]};
            HALF:    res = {16'h0, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tqvp_bus_timeout.sv
// -----------------------------------------------------------------------------
// tqvp_bus_timeout
//
// Loadable down-counter used to bound how long a read strobe may stay active.
// The counter saturates at zero; expired is high whenever it holds zero.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (count -> 0)
//   load       in   load load_value (takes priority over enable)
//   load_value in   value loaded on load
//   clear      in   force count to 0
//   enable     in   decrement by one (saturating at 0)
//   expired    out  count is zero
// -----------------------------------------------------------------------------
module tqvp_bus_timeout #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             clear,
    input  logic             enable,
    output logic             expired
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/tqvp_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tqvp_bus_sequencer
//
// Turns a valid/ready command stream into single accesses on the TinyQV
// peripheral bus and returns one response per command. One command is in
// flight at a time. Illegal or misaligned commands are answered with an error
// without touching the bus.
//
// Optional feature macro: TQVP_BUS_SEQ_TIMEOUT_EN
//   When defined, a read whose data_ready has not been seen by the end of the
//   TIMEOUT_CYCLES-th strobe cycle is aborted with resp_err=1. When undefined,
//   reads wait indefinitely and TIMEOUT_CYCLES only gets a range check.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_write           1 = write, 0 = read
//   cmd_size            00 byte, 01 half, 10 word, 11 illegal
//   cmd_addr/wdata      peripheral register address / LSB-aligned write data
//   resp_valid/ready    response handshake
//   resp_rdata          zero-extended read data (0 for writes and errors)
//   resp_err            illegal, misaligned or timed-out command
//   address, data_in    bus address and write data (registered, held when idle)
//   data_write_n        write strobe: size code when active, 11 when idle
//   data_read_n         read strobe: size code when active, 11 when idle
//   data_out            read data from the peripheral
//   data_ready          read data valid (only observed while reading)
// -----------------------------------------------------------------------------
module tqvp_bus_sequencer
    import tqvp_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [5:0]  address_q, address_d;
    logic [31:0] data_in_q, data_in_d;
    logic [1:0]  write_n_q, write_n_d;
    logic [1:0]  read_n_q, read_n_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        cmd_fire;
    logic        cmd_bad;
    logic        timeout_hit;

    // Gated by rst so the port reads 0 while reset is held, and 1 in the very
    // first cycle after it, without waiting for a registered copy.
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_bad   = (size_e'(cmd_size) == ILLEGAL) ||
                       !is_aligned(size_e'(cmd_size), cmd_addr[1:0]);

`ifdef TQVP_BUS_SEQ_TIMEOUT_EN
    // Loaded with N-1 so the counter reaches zero in the N-th strobe cycle.
    localparam logic [7:0] TmoLoad = 8'(TIMEOUT_CYCLES - 1);

    logic tmo_expired;

    tqvp_bus_timeout #(
        .Width (8)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load       (cmd_fire && !cmd_bad && !cmd_write),
        .load_value (TmoLoad),
        .clear      (state_q == StResp),
        .enable     (state_q == StRead),
        .expired    (tmo_expired)
    );

    // data_ready in the last counted cycle still completes normally.
    assign timeout_hit = tmo_expired && !data_ready;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        write_n_d    = BUS_IDLE;
        read_n_d     = read_n_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (cmd_write) begin
                        state_d   = StWrite;
                        write_n_d = cmd_size;
                        address_d = cmd_addr;
                        data_in_d = cmd_wdata;
                    end else begin
                        state_d   = StRead;
                        read_n_d  = cmd_size;
                        address_d = cmd_addr;
                    end
                end
            end

            StWrite: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end

            StRead: begin
                if (data_ready) begin
                    state_d      = StResp;
                    read_n_d     = BUS_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    // read_n_q still carries the size code of this access
                    resp_rdata_d = mask_rdata(size_e'(read_n_q), data_out);
                end else if (timeout_hit) begin
                    state_d      = StResp;
                    read_n_d     = BUS_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end
            end

            StResp: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            address_q    <= '0;
            data_in_q    <= '0;
            write_n_q    <= BUS_IDLE;
            read_n_q     <= BUS_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            write_n_q    <= write_n_d;
            read_n_q     <= read_n_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = write_n_q;
    assign data_read_n  = read_n_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_tqvp_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tqvp_bus_sequencer
//
// Directed bench for tqvp_bus_sequencer. Inputs change and outputs are sampled
// 1 ns after each rising edge. Timeout checks follow TQVP_BUS_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_tqvp_bus_sequencer;

    localparam int unsigned TIMEOUT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tqvp_bus_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_size     (cmd_size),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command for exactly one edge; returns in cycle N+1.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [5:0] a,
                        input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
        cmd_addr = '0; cmd_wdata = '0; resp_ready = 1'b0; data_out = '0; data_ready = 1'b0;
        tick(); tick();
        vectors++;
        if ({cmd_ready, data_write_n, data_read_n, resp_valid} !== {1'b0, 2'b11, 2'b11, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_held: got rdy=%b wn=%b rn=%b rv=%b want 0 11 11 0",
                     cmd_ready, data_write_n, data_read_n, resp_valid);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_cycle_ready: got %b want 1", cmd_ready);
        end
        tick(); tick();
        vectors++;
        if ({cmd_ready, data_write_n, data_read_n, resp_valid, resp_err, resp_rdata, address, data_in}
            !== {1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 6'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_idle: got rdy=%b wn=%b rn=%b rv=%b err=%b rd=%h a=%h di=%h",
                     cmd_ready, data_write_n, data_read_n, resp_valid, resp_err, resp_rdata,
                     address, data_in);
        end
    endtask

    task automatic test_write_word();
        send(1'b1, 2'b10, 6'h04, 32'hDEADBEEF);
        vectors++;
        if ({data_write_n, data_read_n, address, data_in, resp_valid, cmd_ready}
            !== {2'b10, 2'b11, 6'h04, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL write_strobe: got wn=%b rn=%b a=%h di=%h rv=%b rdy=%b want 10 11 04 deadbeef 0 0",
                     data_write_n, data_read_n, address, data_in, resp_valid, cmd_ready);
        end
        tick();
        vectors++;
        if ({data_write_n, resp_valid, resp_err, resp_rdata, cmd_ready}
            !== {2'b11, 1'b1, 1'b0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL write_resp: got wn=%b rv=%b err=%b rd=%h rdy=%b want 11 1 0 0 0",
                     data_write_n, resp_valid, resp_err, resp_rdata, cmd_ready);
        end
        consume();
        vectors++;
        if ({resp_valid, cmd_ready, address, data_in} !== {1'b0, 1'b1, 6'h04, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL write_after: got rv=%b rdy=%b a=%h di=%h want 0 1 04 deadbeef",
                     resp_valid, cmd_ready, address, data_in);
        end
    endtask

    task automatic test_read_byte();
        data_out = 32'h12345678;
        send(1'b0, 2'b00, 6'h08, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            vectors++;
            if ({data_read_n, data_write_n, resp_valid, address} !== {2'b00, 2'b11, 1'b0, 6'h08}) begin
                miscompares++;
                $display("FAIL read_byte_strobe%0d: got rn=%b wn=%b rv=%b a=%h want 00 11 0 08",
                         i, data_read_n, data_write_n, resp_valid, address);
            end
            if (i == 3) data_ready = 1'b1;
            tick();
        end
        data_ready = 1'b0;
        vectors++;
        if ({data_read_n, resp_valid, resp_err, resp_rdata} !== {2'b11, 1'b1, 1'b0, 32'h00000078}) begin
            miscompares++;
            $display("FAIL read_byte_resp: got rn=%b rv=%b err=%b rd=%h want 11 1 0 00000078",
                     data_read_n, resp_valid, resp_err, resp_rdata);
        end
        consume();
    endtask

    task automatic test_errors();
        logic        wr_t [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  sz_t [3] = '{2'b01, 2'b11, 2'b10};
        logic [5:0]  ad_t [3] = '{6'h03, 6'h10, 6'h06};
        for (int i = 0; i < 3; i++) begin
            send(wr_t[i], sz_t[i], ad_t[i], 32'hFFFF_FFFF);
            vectors++;
            if ({data_write_n, data_read_n, resp_valid, resp_err, resp_rdata, cmd_ready}
                !== {2'b11, 2'b11, 1'b1, 1'b1, 32'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL error_cmd%0d: got wn=%b rn=%b rv=%b err=%b rd=%h rdy=%b want 11 11 1 1 0 0",
                         i, data_write_n, data_read_n, resp_valid, resp_err, resp_rdata, cmd_ready);
            end
            consume();
            vectors++;
            if ({data_write_n, data_read_n, resp_valid, cmd_ready, address} !== {2'b11, 2'b11, 1'b0, 1'b1, 6'h08}) begin
                miscompares++;
                $display("FAIL error_after%0d: got wn=%b rn=%b rv=%b rdy=%b a=%h want 11 11 0 1 08",
                         i, data_write_n, data_read_n, resp_valid, cmd_ready, address);
            end
        end
    endtask

    task automatic test_half_read_hold();
        data_ready = 1'b1;           // ignored while idle
        data_out   = 32'hAABBCCDD;
        tick();
        vectors++;
        if ({data_read_n, resp_valid, cmd_ready} !== {2'b11, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL ready_ignored_idle: got rn=%b rv=%b rdy=%b want 11 0 1",
                     data_read_n, resp_valid, cmd_ready);
        end
        send(1'b0, 2'b01, 6'h06, 32'h0);
        vectors++;
        if ({data_read_n, address, resp_valid} !== {2'b01, 6'h06, 1'b0}) begin
            miscompares++;
            $display("FAIL half_strobe: got rn=%b a=%h rv=%b want 01 06 0",
                     data_read_n, address, resp_valid);
        end
        tick();
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({resp_valid, resp_err, resp_rdata, cmd_ready, data_read_n}
                !== {1'b1, 1'b0, 32'h0000CCDD, 1'b0, 2'b11}) begin
                miscompares++;
                $display("FAIL resp_hold%0d: got rv=%b err=%b rd=%h rdy=%b rn=%b want 1 0 0000ccdd 0 11",
                         i, resp_valid, resp_err, resp_rdata, cmd_ready, data_read_n);
            end
            data_out = data_out + 32'h01010101;
            tick();
        end
        consume();
        vectors++;
        if ({resp_valid, cmd_ready} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL resp_release: got rv=%b rdy=%b want 0 1", resp_valid, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        data_ready = 1'b0;
        data_out   = 32'h55555555;
        send(1'b0, 2'b10, 6'h0C, 32'h0);
`ifdef TQVP_BUS_SEQ_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if ({data_read_n, resp_valid} !== {2'b10, 1'b0}) begin
                miscompares++;
                $display("FAIL timeout_strobe%0d: got rn=%b rv=%b want 10 0", i, data_read_n, resp_valid);
            end
            tick();
        end
        vectors++;
        if ({data_read_n, resp_valid, resp_err, resp_rdata} !== {2'b11, 1'b1, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_resp: got rn=%b rv=%b err=%b rd=%h want 11 1 1 0",
                     data_read_n, resp_valid, resp_err, resp_rdata);
        end
`else
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if ({data_read_n, resp_valid} !== {2'b10, 1'b0}) begin
                miscompares++;
                $display("FAIL wait_strobe%0d: got rn=%b rv=%b want 10 0", i, data_read_n, resp_valid);
            end
            tick();
        end
        data_ready = 1'b1;
        data_out   = 32'h0BADF00D;
        tick();
        data_ready = 1'b0;
        vectors++;
        if ({data_read_n, resp_valid, resp_err, resp_rdata} !== {2'b11, 1'b1, 1'b0, 32'h0BADF00D}) begin
            miscompares++;
            $display("FAIL wait_resp: got rn=%b rv=%b err=%b rd=%h want 11 1 0 0badf00d",
                     data_read_n, resp_valid, resp_err, resp_rdata);
        end
`endif
        consume();
    endtask

    task automatic test_ready_last_cycle();
        data_out = 32'h87654321;
        send(1'b0, 2'b10, 6'h10, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if ({data_read_n, resp_valid} !== {2'b10, 1'b0}) begin
                miscompares++;
                $display("FAIL last_cycle_strobe%0d: got rn=%b rv=%b want 10 0", i, data_read_n, resp_valid);
            end
            if (i == 4) data_ready = 1'b1;
            tick();
        end
        data_ready = 1'b0;
        vectors++;
        if ({data_read_n, resp_valid, resp_err, resp_rdata} !== {2'b11, 1'b1, 1'b0, 32'h87654321}) begin
            miscompares++;
            $display("FAIL last_cycle_resp: got rn=%b rv=%b err=%b rd=%h want 11 1 0 87654321",
                     data_read_n, resp_valid, resp_err, resp_rdata);
        end
        consume();
    endtask

    task automatic test_rst_mid_read();
        send(1'b0, 2'b00, 6'h20, 32'h0);
        tick();
        vectors++;
        if (data_read_n !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_pre_strobe: got rn=%b want 00", data_read_n);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({data_read_n, data_write_n, resp_valid, cmd_ready, address, data_in}
            !== {2'b11, 2'b11, 1'b0, 1'b0, 6'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL rst_mid_read: got rn=%b wn=%b rv=%b rdy=%b a=%h di=%h want 11 11 0 0 0 0",
                     data_read_n, data_write_n, resp_valid, cmd_ready, address, data_in);
        end
        rst        = 1'b0;
        data_ready = 1'b1;
        tick(); tick();
        data_ready = 1'b0;
        vectors++;
        if ({resp_valid, cmd_ready, data_read_n} !== {1'b0, 1'b1, 2'b11}) begin
            miscompares++;
            $display("FAIL rst_no_resp: got rv=%b rdy=%b rn=%b want 0 1 11",
                     resp_valid, cmd_ready, data_read_n);
        end
    endtask

    initial begin
        test_reset();
        test_write_word();
        test_read_byte();
        test_errors();
        test_half_read_hold();
        test_timeout();
        test_ready_last_cycle();
        test_rst_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
